branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Sits on the resolution side of the 2-bit saturating-counter branch predictor. It captures each prediction issued at fetch into an in-order in-flight queue, and compares the oldest entry against the actual outcome when the branch resolves. It then drives the predictor's update inputs (branch/taken) and flags mispredicts, with a pipeline flush of younger in-flight predictions. It also keeps saturating branch and mispredict statistics.

Parameters:
DEPTH, 4, max in-flight predictions; power of two, >=2
CNT_W, 16, width of statistic counters
OCC_W, $clog2(DEPTH+1), occupancy width (derived, not overridden)

Ports:
clk  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
pred_valid  input  1  new prediction offered this cycle
pred_taken  input  1  predicted direction (predictor's prediction output)
pred_ready  output  1  combinational: !full
res_valid  input  1  oldest in-flight branch resolves this cycle
res_taken  input  1  actual direction
upd_branch  output  1  registered pulse to predictor branch input
upd_taken  output  1  registered, valid with upd_branch; equals res_taken
mispredict  output  1  registered 1-cycle pulse, prediction != outcome
res_error  output  1  sticky: resolution arrived with queue empty
occupancy  output  OCC_W  entries currently queued
empty  output  1  occupancy == 0
full  output  1  occupancy == DEPTH
branch_count  output  CNT_W  resolved branches, saturating
mispredict_count  output  CNT_W  mispredicts, saturating

Behaviour:
- Reset (async, any time, including mid-operation): queue emptied (rd/wr pointers 0, occupancy 0), so empty=1, full=0, pred_ready=1. upd_branch, upd_taken, mispredict, res_error and both counters go to 0.
- Queue: circular buffer, DEPTH x 1 bit; pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Push: occurs when pred_valid && pred_ready. When full, the push is refused even if a pop happens the same cycle; there is no pass-through.
- Pop: occurs when res_valid && !empty, and compares head bit with res_taken.
- Resolve on empty: res_valid && empty means no pop and no update pulse. res_error sets and holds until reset. A simultaneous push is still accepted; there is no bypass.
- Latency: one cycle. At the edge after an accepted resolution: upd_branch=1, upd_taken=res_taken, mispredict=(head!=res_taken). Outputs are 0 in any cycle without an accepted resolution in the prior cycle.
- Mispredict flush: at the same edge the mispredict is registered, the whole queue is cleared (rd=wr=0, occupancy 0). A push offered in that cycle is dropped, because it is younger than the mispredicted branch.
- Correct predict with simultaneous push: the pop and push both happen and occupancy is unchanged.
- Counters: branch_count += 1 per accepted resolution; mispredict_count += 1 per mispredict. Both hold at 2^CNT_W-1 with no wrap. Counters are not cleared by flush.
- Invariant: occupancy <= DEPTH; full and empty are never both 1.

Decomposition:
- Shared package bp_pkg: default DEPTH and CNT_W constants, and a struct/typedef for the update bundle {branch, taken}. The predictor reuses this bundle.
- One natural sub-module: bp_pred_fifo, a 1-bit-wide circular FIFO with a synchronous clear input used for the flush. The counters and compare logic stay in the top module.

Test Plan:
- Reset then idle: after reset, occupancy=0, empty=1, pred_ready=1, all pulses 0, counters 0. Assert reset mid-run with 3 entries queued; occupancy goes to 0 immediately, without waiting for clk.
- Fill to full: push 1,0,1,1 with DEPTH=4. Expect full=1, pred_ready=0. A 5th push is refused and occupancy stays 4.
- Correct resolves: with queue 1,0, resolve taken=1 then taken=0. Expect upd_branch pulses one cycle after each resolve, upd_taken 1 then 0, mispredict 0, branch_count=2, empty=1.
- Mispredict flush: queue 0,1,1; resolve taken=1 while pushing 0. Next cycle: mispredict=1, upd_taken=1, occupancy=0 (push dropped), mispredict_count=1.
- Empty resolve: res_valid=1 with empty queue. Expect no upd_branch, res_error=1 and held, counters unchanged.
- Saturation and wrap: CNT_W=2, run 5 correct resolves interleaved with pushes so the pointers wrap past 3. Expect branch_count stays at 3 and head order is preserved across the wrap.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and types for the branch predictor and its resolution side.
package bp_pkg;

  localparam int BP_DEPTH = 4;
  localparam int BP_CNT_W = 16;

  // Update bundle consumed by the 2-bit saturating-counter predictor.
  typedef struct packed {
    logic branch;
    logic taken;
  } bp_upd_t;

endpackage

// File: rtl/bp_pred_fifo.sv
// 1-bit-wide circular FIFO of in-flight predictions with a synchronous clear for flushes.
module bp_pred_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             din_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic [OCC_W-1:0] occupancy_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == OCC_W'(DEPTH));
  assign occupancy_o = cnt_q;
  assign head_o      = mem_q[rd_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Clear wins over push/pop: anything offered in a flush cycle is discarded.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PTR_W'(1);
      if (pop_ok)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches in-order predictions against resolved outcomes, drives predictor updates,
// flags mispredicts (flushing younger predictions) and keeps saturating statistics.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter  int DEPTH = BP_DEPTH,
  parameter  int CNT_W = BP_CNT_W,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_branch,
  output logic             upd_taken,
  output logic             mispredict,
  output logic             res_error,
  output logic [OCC_W-1:0] occupancy,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  logic       head;
  logic       pop, push, miss;
  bp_upd_t    upd_q, upd_d;
  logic       mispredict_q, res_error_q, res_error_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  assign pred_ready = !full;
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && !empty;
  assign miss       = pop && (head != res_taken);

  bp_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_i       (reset),
    .clr_i       (miss),
    .push_i      (push),
    .din_i       (pred_taken),
    .pop_i       (pop),
    .head_o      (head),
    .occupancy_o (occupancy),
    .empty_o     (empty),
    .full_o      (full)
  );

  always_comb begin
    upd_d.branch       = pop;
    upd_d.taken        = pop && res_taken;
    res_error_d        = res_error_q || (res_valid && empty);
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    // Statistics stick at all-ones rather than wrapping.
    if (pop && (branch_count_q != '1))
      branch_count_d = branch_count_q + CNT_W'(1);
    if (miss && (mispredict_count_q != '1))
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_q              <= '0;
      mispredict_q       <= 1'b0;
      res_error_q        <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      upd_q              <= upd_d;
      mispredict_q       <= miss;
      res_error_q        <= res_error_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign upd_branch       = upd_q.branch;
  assign upd_taken        = upd_q.taken;
  assign mispredict       = mispredict_q;
  assign res_error        = res_error_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit (DEPTH=4, CNT_W=2 to reach saturation).
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             pred_valid = 1'b0, pred_taken = 1'b0;
  logic             res_valid = 1'b0, res_taken = 1'b0;
  logic             pred_ready, upd_branch, upd_taken, mispredict, res_error;
  logic [OCC_W-1:0] occupancy;
  logic             empty, full;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .pred_ready       (pred_ready),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .upd_branch       (upd_branch),
    .upd_taken        (upd_taken),
    .mispredict       (mispredict),
    .res_error        (res_error),
    .occupancy        (occupancy),
    .empty            (empty),
    .full             (full),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: in-flight predictions, expected {taken, mispredict} per resolution.
  logic       mq[$];
  logic [1:0] exp_q[$];
  int         bc = 0, mc = 0;
  logic       err = 1'b0;
  int         step_no = 0;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    bc  = 0;
    mc  = 0;
    err = 1'b0;
  endtask

  task automatic check_state();
    chk("occupancy", int'(occupancy), mq.size());
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("pred_ready", int'(pred_ready), int'(mq.size() != DEPTH));
    chk("branch_count", int'(branch_count), bc);
    chk("mispredict_count", int'(mispredict_count), mc);
    chk("res_error", int'(res_error), int'(err));
  endtask

  task automatic step(input logic pv, input logic pt, input logic rv, input logic rt);
    logic       do_push, do_pop, h, mis;
    logic [1:0] e;
    pred_valid = pv;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
    do_push = pv && (mq.size() < DEPTH);
    do_pop  = rv && (mq.size() > 0);
    if (rv && mq.size() == 0) err = 1'b1;
    if (do_pop) begin
      h   = mq[0];
      mis = (h != rt);
      exp_q.push_back({rt, mis});
      if (bc < CMAX) bc++;
      if (mis && mc < CMAX) mc++;
      if (mis) mq.delete();
      else begin
        void'(mq.pop_front());
        if (do_push) mq.push_back(pt);
      end
    end else if (do_push) begin
      mq.push_back(pt);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("upd_branch", int'(upd_branch), 1);
      chk("upd_taken", int'(upd_taken), int'(e[1]));
      chk("mispredict", int'(mispredict), int'(e[0]));
    end else begin
      chk("upd_branch_idle", int'(upd_branch), 0);
      chk("upd_taken_idle", int'(upd_taken), 0);
      chk("mispredict_idle", int'(mispredict), 0);
    end
    check_state();
    step_no++;
    $display("step %0d pv=%0b pt=%0b rv=%0b rt=%0b -> occ=%0d upd=%0b/%0b mis=%0b bc=%0d mc=%0d err=%0b",
             step_no, pv, pt, rv, rt, occupancy, upd_branch, upd_taken, mispredict,
             branch_count, mispredict_count, res_error);
  endtask

  // Reset asserted between edges; state must clear before any clock edge arrives.
  task automatic do_reset();
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_occupancy_async", int'(occupancy), 0);
    chk("rst_empty_async", int'(empty), 1);
    chk("rst_full_async", int'(full), 0);
    chk("rst_pred_ready_async", int'(pred_ready), 1);
    chk("rst_upd_branch", int'(upd_branch), 0);
    chk("rst_upd_taken", int'(upd_taken), 0);
    chk("rst_mispredict", int'(mispredict), 0);
    chk("rst_res_error", int'(res_error), 0);
    chk("rst_branch_count", int'(branch_count), 0);
    chk("rst_mispredict_count", int'(mispredict_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset applied");
  endtask

  initial begin
    logic b;
    @(posedge clk);
    #1;
    do_reset();
    step(0, 0, 0, 0);

    // Fill to full, then a refused fifth push.
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("full_after_fill", int'(full), 1);

    // Async reset with 3 entries queued.
    do_reset();
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("three_queued", int'(occupancy), 3);
    do_reset();

    // Two correct resolves.
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("correct_bc", int'(branch_count), 2);

    // Mispredict with a simultaneous push that must be dropped.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 1);
    chk("flush_occupancy", int'(occupancy), 0);
    step(0, 0, 0, 0);

    // Resolve on empty: sticky error, no pulse, push still accepted.
    do_reset();
    step(0, 0, 1, 1);
    step(1, 1, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Saturation and pointer wrap with CNT_W=2.
    do_reset();
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      b = mq[0];
      step(1, logic'($urandom_range(0, 1)), 1, b);
    end
    while (mq.size() > 0) begin
      b = mq[0];
      step(0, 0, 1, b);
    end
    step(0, 0, 0, 0);
    chk("sat_bc", int'(branch_count), CMAX);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
